// File: rtl/usb_arb_pkg.sv
// Shared state encoding and round-robin pick helper for the USB endpoint arbiters.
package usb_arb_pkg;

    localparam int MAX_EPS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // First eligible client at or after ptr, wrapping modulo n (ptr < n assumed).
    // Walking k downwards lets the smallest rotation distance win last.
    function automatic pick_t rr_pick(input logic [MAX_EPS-1:0] eligible,
                                      input logic [3:0]         ptr,
                                      input logic [4:0]         n);
        pick_t      r;
        logic [4:0] c;
        r = '0;
        for (int k = MAX_EPS - 1; k >= 0; k--) begin
            c = {1'b0, ptr} + 5'(k);
            if (c >= n) c = c - n;
            if ((5'(k) < n) && eligible[c[3:0]]) begin
                r.found = 1'b1;
                r.idx   = c[3:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_rr_picker.sv
// Combinational priority rotator: picks the first eligible client at or after ptr.
module usb_rr_picker
    import usb_arb_pkg::*;
#(
    parameter int NUM_IN_EPS = 4
) (
    input  logic [NUM_IN_EPS-1:0] eligible,
    input  logic [3:0]            ptr,
    output logic                  found,
    output logic [3:0]            idx
);

    pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_EPS'(eligible), ptr, 5'(NUM_IN_EPS));
        found = pick.found;
        idx   = pick.idx;
    end

endmodule

// File: rtl/usb_in_ep_rr_arb.sv
// Round-robin arbiter sharing the usb_fs_pe IN interface among NUM_IN_EPS endpoints,
// with a hold watchdog. Define IN_ARB_EP0_PRIORITY_EN to give client 0 absolute priority.
module usb_in_ep_rr_arb
    import usb_arb_pkg::*;
#(
    parameter int NUM_IN_EPS = 4,
    parameter int MAX_HOLD   = 4096,
    parameter int HOLD_W     = 13
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN_EPS-1:0]   in_ep_req,
    output logic [NUM_IN_EPS-1:0]   in_ep_grant,
    input  logic [NUM_IN_EPS-1:0]   in_ep_data_put,
    input  logic [8*NUM_IN_EPS-1:0] in_ep_data,
    input  logic [NUM_IN_EPS-1:0]   in_ep_data_done,
    input  logic [NUM_IN_EPS-1:0]   in_ep_stall,
    output logic [NUM_IN_EPS-1:0]   in_ep_acked,
    output logic                    pe_data_put,
    output logic [7:0]              pe_data,
    output logic                    pe_data_done,
    output logic                    pe_stall,
    input  logic                    pe_acked,
    output logic [3:0]              grant_idx,
    output logic                    grant_valid,
    output logic [NUM_IN_EPS-1:0]   revoked,
    output arb_state_t              dbg_state
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [3:0]        LAST_IDX   = 4'(NUM_IN_EPS - 1);

    arb_state_t            state, state_nxt;
    logic [3:0]            grant_idx_nxt, rr_ptr, rr_ptr_nxt, ptr_after_owner;
    logic [HOLD_W-1:0]     hold_cnt, hold_cnt_nxt;
    logic [NUM_IN_EPS-1:0] revoked_nxt, eligible, grant_oh;
    logic                  pick_found, owner_req, owner_busy, advance_ptr;
    logic [3:0]            pick_idx;

    assign eligible    = in_ep_req & ~revoked;
    assign grant_valid = (state == GRANT);
    assign dbg_state   = state;
    assign in_ep_grant = grant_oh;

    usb_rr_picker #(.NUM_IN_EPS(NUM_IN_EPS)) u_picker (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // The PE side follows the registered grant, so a done on the release cycle still passes.
    always_comb begin
        grant_oh     = '0;
        in_ep_acked  = '0;
        pe_data_put  = 1'b0;
        pe_data      = '0;
        pe_data_done = 1'b0;
        pe_stall     = 1'b0;
        for (int i = 0; i < NUM_IN_EPS; i++) begin
            if (grant_valid && (grant_idx == 4'(i))) begin
                grant_oh[i]    = 1'b1;
                in_ep_acked[i] = pe_acked;
                pe_data_put    = in_ep_data_put[i];
                pe_data        = in_ep_data[8*i +: 8];
                pe_data_done   = in_ep_data_done[i];
                pe_stall       = in_ep_stall[i];
            end
        end
    end

    assign owner_req       = |(in_ep_req & grant_oh);
    assign owner_busy      = pe_data_put | pe_data_done | pe_stall | pe_acked;
    assign ptr_after_owner = (grant_idx == LAST_IDX) ? 4'd0 : grant_idx + 4'd1;

`ifdef IN_ARB_EP0_PRIORITY_EN
    // EP0 grants leave the pointer alone so the other clients keep their rotation.
    assign advance_ptr = (grant_idx != 4'd0);
`else
    assign advance_ptr = 1'b1;
`endif

    always_comb begin
        state_nxt     = state;
        grant_idx_nxt = grant_idx;
        rr_ptr_nxt    = rr_ptr;
        hold_cnt_nxt  = hold_cnt;
        revoked_nxt   = revoked & in_ep_req;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt     = GRANT;
                    hold_cnt_nxt  = '0;
                    grant_idx_nxt = pick_idx;
`ifdef IN_ARB_EP0_PRIORITY_EN
                    if (eligible[0]) grant_idx_nxt = 4'd0;
`endif
                end
            end
            GRANT: begin
                // Release outranks the watchdog when both happen on one cycle.
                if (!owner_req) begin
                    state_nxt = GAP;
                    if (advance_ptr) rr_ptr_nxt = ptr_after_owner;
                end else if (owner_busy) begin
                    hold_cnt_nxt = '0;
                end else if (hold_cnt >= HOLD_LIMIT) begin
                    state_nxt   = GAP;
                    revoked_nxt = revoked_nxt | grant_oh;
                    if (advance_ptr) rr_ptr_nxt = ptr_after_owner;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            revoked   <= '0;
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_idx_nxt;
            rr_ptr    <= rr_ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
            revoked   <= revoked_nxt;
        end
    end

endmodule

// File: doc/usb_in_ep_rr_arb.md
Name: usb_in_ep_rr_arb

Overview:
- Parametrised round-robin arbiter between NUM_IN_EPS IN-endpoint clients (control, DFU, CDC, ...) and the single IN interface of the full-speed protocol engine.
- Replaces the fixed one-endpoint hookup, so more than one IN endpoint can share usb_fs_pe.
- Adds a hold watchdog that revokes a grant from a client that stalls the bus.
- Sits between the endpoint blocks and usb_fs_pe, in the clk domain.

Parameters:
- NUM_IN_EPS, 4: number of IN clients, 1..16.
- MAX_HOLD, 4096: idle cycles allowed while granted before revocation, >=2.
- HOLD_W, 13: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  endpoint-domain clock.
- reset  in  1  synchronous, active-high.
- in_ep_req  in  NUM_IN_EPS  per-client request.
- in_ep_grant  out  NUM_IN_EPS  one-hot grant.
- in_ep_data_put  in  NUM_IN_EPS  per-client byte strobe.
- in_ep_data  in  8*NUM_IN_EPS  client i byte on bits [8i+7:8i].
- in_ep_data_done  in  NUM_IN_EPS  per-client packet-complete.
- in_ep_stall  in  NUM_IN_EPS  per-client stall.
- in_ep_acked  out  NUM_IN_EPS  ack demuxed to the granted client.
- pe_data_put  out  1  muxed put to the PE.
- pe_data  out  8  muxed byte.
- pe_data_done  out  1  muxed done.
- pe_stall  out  1  muxed stall.
- pe_acked  in  1  ack from the PE.
- grant_idx  out  4  index of the current grant; valid when grant_valid.
- grant_valid  out  1  a grant is active.
- revoked  out  NUM_IN_EPS  sticky revoke flag per client.

Behaviour:
- Reset values: in_ep_grant=0, grant_valid=0, grant_idx=0, revoked=0, rr_ptr=0, hold_cnt=0. All pe_* and in_ep_acked outputs are 0.
- State machine has three states: IDLE, GRANT, GAP.
- IDLE:
  - eligible = in_ep_req & ~revoked.
  - If eligible is non-zero, pick the first set bit at or after rr_ptr, wrapping modulo NUM_IN_EPS.
  - Registered grant: asserted the cycle after req is seen, so request-to-grant latency is 1 cycle.
  - Go to GRANT.
- GRANT:
  - Muxing is combinational from the registered grant_idx: pe_data_put, pe_data, pe_data_done and pe_stall come from client grant_idx.
  - in_ep_acked[grant_idx]=pe_acked; all other bits are 0.
  - Inputs from non-granted clients are ignored.
- Release: when in_ep_req[grant_idx] falls, clear the grant on the next edge, set rr_ptr=(grant_idx+1) mod N, and go to GAP.
- GAP: one cycle with no grant (bus turnaround), then IDLE.
- Hold watchdog:
  - hold_cnt is cleared on entry to GRANT and on any put/done/stall/pe_acked cycle; otherwise it increments, saturating.
  - When hold_cnt reaches MAX_HOLD: set revoked[grant_idx], drop the grant, advance rr_ptr, go to GAP.
  - A client with revoked set is never eligible. revoked[i] clears the cycle after in_ep_req[i] is seen low.
- Simultaneous release and timeout on the same cycle: treat as a normal release; revoked is not set.
- A req deasserted during GAP has no effect.
- A done pulse on the cycle the grant drops is still forwarded, because the mux follows the registered grant for that cycle.
- NUM_IN_EPS=1: degenerates to a pass-through with the 1-cycle grant latency and the GAP cycle.
- Reset mid-packet: all state returns to reset values on the next edge. No partial pe_data_done is generated.

Optional Feature:
- Macro IN_ARB_EP0_PRIORITY_EN.
- Defined: in IDLE, if eligible[0] is set, client 0 is granted regardless of rr_ptr. rr_ptr is not advanced after an EP0 grant, so round-robin order among the other clients is preserved.
- Undefined: pure round-robin, with EP0 treated like any other client.

Decomposition:
- Package usb_arb_pkg holds:
  - the state encoding (IDLE/GRANT/GAP, 2 bits);
  - the function rr_pick(eligible, ptr) returning index+found;
  - the constant MAX_EPS=16.
- One sub-module, usb_rr_picker: a combinational priority rotator, parametrised by NUM_IN_EPS. It is reused by the future OUT arbiter.

Test Plan:
1. N=4, req=4'b1010 from reset (rr_ptr=0):
   - grant=4'b0010 on cycle 2, i.e. 1 cycle after req;
   - drop req[1], then one GAP cycle;
   - then grant=4'b1000, and rr_ptr=2 while client 3 is granted.
2. N=4, granted client 2 asserts put with data 8'hA5 for 3 cycles, then done:
   - pe_data=A5 with pe_data_put high for exactly 3 cycles;
   - pe_data_done for 1 cycle;
   - a pe_acked pulse appears only on in_ep_acked[2].
3. MAX_HOLD=16, client 1 granted with no activity:
   - on cycle 16 revoked[1]=1, grant drops, and client 3 (req high) is granted after GAP;
   - client 1 is not re-granted until its req goes low for 1 cycle and then high again.
4. req[0] and req[2] high, with req[2] having been first to request:
   - with IN_ARB_EP0_PRIORITY_EN, client 0 wins first;
   - without it, with rr_ptr=1, client 2 wins first.
5. Reset asserted 2 cycles into a granted transfer: all grants are 0, pe_* are 0 and revoked is 0 on the next edge.
6. Release and timeout on the same cycle (MAX_HOLD reached as req falls): revoked stays 0 and rr_ptr advances normally.
